int_root_seq: RTL
=================

INT_ROOT_SEQ -- requirements
Module: int_root_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; it must be even and at least 4.
REQ-002 The block SHALL have derived parameter RW = WIDTH/2, giving the root width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand request.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = square root, 1 = cube root.
REQ-008 The block SHALL have port number, input, WIDTH bits: unsigned operand.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port root, output, RW bits: floor(number^(1/2)) or floor(number^(1/3)), zero-extended.
REQ-012 The block SHALL have port rem, output, WIDTH bits: number - root^2 or number - root^3.
REQ-013 The block SHALL have port exact, output, 1 bit: high when rem == 0.
REQ-014 The block SHALL have port busy, output, 1 bit: high in the CALC state.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept happens on a rising edge with IDLE and in_valid=1; it SHALL latch number and mode, clear root, set bit index to N-1, and move to CALC.
REQ-018 N SHALL be RW for square root and ceil(WIDTH/3) for cube root (N = 16 and 11 at WIDTH=32).
REQ-019 Each CALC edge SHALL form trial = root | (1<<idx) and keep the bit if trial^k <= operand, where k = 2 or 3.
REQ-020 After the bit test, each CALC edge SHALL decrement idx.
REQ-021 Trial powers SHALL use at least 3*RW bits with no truncation or overflow.
REQ-022 The CALC edge that processes idx=0 SHALL compute rem and exact and move to DONE.
REQ-023 Latency SHALL be exactly N rising edges from the accepting edge to out_valid=1.
REQ-024 root, rem and exact SHALL hold stable while out_valid=1 and out_ready=0, with no timeout.
REQ-025 On an edge with DONE and out_ready=1, the FSM SHALL return to IDLE; outputs keep their values but are invalid.
REQ-026 An accept cannot occur in the same cycle as a result handoff (in_ready=0 in DONE); minimum issue interval is N+1 cycles.
REQ-027 in_valid, mode and number SHALL be ignored outside IDLE; mid-operation input changes SHALL not affect the result.
REQ-028 Operand 0 SHALL give root=0, rem=0, exact=1 with full latency N, with no early exit.
REQ-029 The maximum operand (all ones) SHALL produce a correct result with no wrap in the trial power or in rem.
REQ-030 A result SHALL be produced for any operand, with no error state.

Reset
REQ-031 rst=1 on a rising edge SHALL force IDLE regardless of state and take priority over all handshakes.
REQ-032 Reset SHALL set in_ready=1, out_valid=0, busy=0, root=0, rem=0 and exact=0.
REQ-033 Reset in CALC or DONE SHALL abandon the operation with no out_valid pulse.
REQ-034 After reset deasserts, the first accept is allowed on the next edge.

Verification (WIDTH=32)
REQ-035 Square root of 1000000 (mode=0) SHALL give root=1000, rem=0, exact=1, out_valid exactly 16 edges after accept.
REQ-036 Cube root of 26 (mode=1) SHALL give root=2, rem=18, exact=0, out_valid 11 edges after accept.
REQ-037 Cube root of 1000 SHALL give root=10, rem=0, exact=1.
REQ-038 Operand 0xFFFFFFFF SHALL give: square root 65535 with rem=131070; cube root 1625 with rem=3951670.
REQ-039 Holding out_ready=0 for 5 cycles SHALL keep out_valid=1 and outputs stable; the FSM SHALL return to IDLE the edge after out_ready=1, and in_ready=1 the following cycle.
REQ-040 rst=1 at the 5th CALC cycle SHALL give in_ready=1 and out_valid=0 next cycle; a fresh sqrt of 144 SHALL then give 12, rem 0.

Source files
------------

// File: rtl/int_root_seq.sv
// rtl/int_root_seq.sv - sequential bit-serial integer square/cube root
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   mode               0 = square root, 1 = cube root (latched on accept)
//   number             unsigned WIDTH-bit operand (latched on accept)
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   root               floor root, RW bits
//   rem                number - root^k, WIDTH bits
//   exact              rem == 0
//   busy               high while iterating (CALC)
//
// One result bit is resolved per CALC cycle, MSB first. The operation takes
// RW cycles for a square root and ceil(WIDTH/3) cycles for a cube root.
module int_root_seq #(
    parameter int WIDTH = 32,
    localparam int RW = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    root,
    output logic [WIDTH-1:0] rem,
    output logic             exact,
    output logic             busy
);

    // Power width: a RW-bit value cubed needs 3*RW bits.
    localparam int PW  = 3 * RW;
    localparam int NSQ = RW;
    localparam int NCU = (WIDTH + 2) / 3;
    localparam int IW  = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] operand;
    logic             mode_r;
    logic [IW-1:0]    idx;
    // Power of the root accumulated so far; never exceeds the operand,
    // so WIDTH bits suffice.
    logic [WIDTH-1:0] pow;

    logic [RW-1:0]    trial;
    logic [PW-1:0]    tw;
    logic [PW-1:0]    sq;
    logic [PW-1:0]    cu;
    logic [PW-1:0]    pow_trial;
    logic [PW-1:0]    op_ext;
    logic             keep;
    logic [WIDTH-1:0] pow_sel;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        trial     = root | (RW'(1) << idx);
        tw        = {{(PW-RW){1'b0}}, trial};
        sq        = tw * tw;
        cu        = sq * tw;
        pow_trial = mode_r ? cu : sq;
        op_ext    = {{(PW-WIDTH){1'b0}}, operand};
        keep      = (pow_trial <= op_ext);
        // When the bit is kept pow_trial <= operand, so its low bits are exact.
        pow_sel   = keep ? pow_trial[WIDTH-1:0] : pow;
        rem_next  = operand - pow_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            operand <= '0;
            mode_r  <= 1'b0;
            idx     <= '0;
            pow     <= '0;
            root    <= '0;
            rem     <= '0;
            exact   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand <= number;
                        mode_r  <= mode;
                        root    <= '0;
                        pow     <= '0;
                        idx     <= mode ? IW'(NCU - 1) : IW'(NSQ - 1);
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (keep) begin
                        root <= trial;
                        pow  <= pow_trial[WIDTH-1:0];
                    end
                    idx <= idx - IW'(1);
                    if (idx == '0) begin
                        rem   <= rem_next;
                        exact <= (rem_next == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == CALC);
    assign out_valid = (state == DONE);

endmodule
